i2c_write: RTL and testbench

- I2C single-byte register write master: START, device write address, register address, data byte, STOP.
- Write-direction companion of the existing I2C register read master. Used to program RTC (DS3231M) control/time registers over the same SCL/SDA pins.
- Same pad model: open-drain SDA built outside from sda_reg/en; SDA read back on sda.
- Adds a programmable SCL rate and bounded NACK retry.

---
 rtl/i2c_write.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_write.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write.sv
//------------------------------------------------------------------------------
// Module   : i2c_write
// Brief    : I2C single-byte register write master (START, dev addr, reg addr,
//            data, STOP) with programmable SCL quarter-phase and NACK retry.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module i2c_write #(
   parameter int CLK_DIV   = 4,
   parameter int ACK_RETRY = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] deviceaddw,
   input  logic [7:0] wraddr,
   input  logic [7:0] wrdat,
   input  logic       sda,
   output logic       scl,
   output logic       sda_reg,
   output logic       en,
   output logic       busy,
   output logic       over,
   output logic       nack
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int RW = (ACK_RETRY > 0) ? $clog2(ACK_RETRY + 1) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_BIT   = 3'd2;
   localparam logic [2:0] S_ACK   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;
   localparam logic [2:0] S_BUF   = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   logic [2:0]    r_state;
   logic [2:0]    w_next;
   logic [DW-1:0] r_div;
   logic [1:0]    r_q;
   logic [2:0]    r_bit;
   logic [1:0]    r_byte;
   logic [RW-1:0] r_retry;
   logic          r_fail;
   logic          r_nack;
   logic [7:0]    r_dev;
   logic [7:0]    r_reg;
   logic [7:0]    r_dat;

   logic       w_accept;
   logic       w_qend;
   logic       w_step_end;
   logic       w_can_retry;
   logic [7:0] w_cur_byte;
   logic       w_bit_val;

   assign w_accept   = (r_state == S_IDLE) && start;
   assign w_qend     = (r_div == DIV_LAST);
   assign w_step_end = w_qend && (r_q == 2'd3);
   assign w_cur_byte = (r_byte == 2'd0) ? r_dev : ((r_byte == 2'd1) ? r_reg : r_dat);
   assign w_bit_val  = w_cur_byte[r_bit];

   generate
      if (ACK_RETRY > 0) begin : g_retry
         assign w_can_retry = (r_retry < RW'(ACK_RETRY));
      end else begin : g_no_retry
         assign w_can_retry = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_START;
         S_START: if (w_step_end) w_next = S_BIT;
         S_BIT:   if (w_step_end) w_next = (r_bit == 3'd0) ? S_ACK : S_BIT;
         S_ACK: begin
            if (w_step_end) begin
               w_next = (r_fail || (r_byte == 2'd2)) ? S_STOP : S_BIT;
            end
         end
         S_STOP: begin
            if (w_step_end) begin
               w_next = (r_fail && w_can_retry) ? S_BUF : S_DONE;
            end
         end
         S_BUF:   if (w_step_end) w_next = S_START;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      scl     = 1'b1;
      sda_reg = 1'b1;
      en      = 1'b1;
      busy    = 1'b1;
      over    = 1'b0;
      case (r_state)
         S_IDLE: busy = 1'b0;
         S_START: begin
            sda_reg = (r_q == 2'd0);
            scl     = (r_q != 2'd3);
         end
         S_BIT: begin
            scl     = r_q[1];
            sda_reg = w_bit_val;
         end
         S_ACK: begin
            scl = r_q[1];
            en  = 1'b0;
         end
         S_STOP: begin
            scl     = r_q[1];
            sda_reg = (r_q == 2'd3);
         end
         S_BUF: begin
            scl     = 1'b1;
            sda_reg = 1'b1;
         end
         S_DONE: begin
            busy = 1'b0;
            over = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div   <= '0;
         r_q     <= 2'd0;
         r_bit   <= 3'd7;
         r_byte  <= 2'd0;
         r_retry <= '0;
         r_fail  <= 1'b0;
         r_nack  <= 1'b0;
         r_dev   <= 8'd0;
         r_reg   <= 8'd0;
         r_dat   <= 8'd0;
      end else begin
         if (w_accept) begin
            r_dev   <= deviceaddw;
            r_reg   <= wraddr;
            r_dat   <= wrdat;
            r_nack  <= 1'b0;
            r_retry <= '0;
            r_fail  <= 1'b0;
            r_div   <= '0;
            r_q     <= 2'd0;
         end else if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
            r_div <= '0;
            r_q   <= 2'd0;
         end else if (w_qend) begin
            r_div <= '0;
            r_q   <= r_q + 2'd1;
         end else begin
            r_div <= r_div + DW'(1);
         end

         // every attempt, including retries, restarts from the device address
         if (r_state == S_START) begin
            r_bit  <= 3'd7;
            r_byte <= 2'd0;
            r_fail <= 1'b0;
         end
         if ((r_state == S_BIT) && w_step_end) begin
            r_bit <= r_bit - 3'd1;
         end
         if ((r_state == S_ACK) && w_step_end) begin
            r_byte <= r_byte + 2'd1;
         end
         if ((r_state == S_ACK) && (r_q == 2'd2) && w_qend && sda) begin
            r_fail <= 1'b1;
         end
         if ((r_state == S_STOP) && w_step_end) begin
            if (r_fail && w_can_retry) begin
               r_retry <= r_retry + RW'(1);
            end else begin
               r_nack <= r_fail;
            end
         end
      end
   end

   assign nack = r_nack;

endmodule

`default_nettype wire

// File: tb/tb_i2c_write.sv
//------------------------------------------------------------------------------
// Module   : tb_i2c_write
// Brief    : Bench for i2c_write; bus decoder/slave plus transaction-level model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2c_write;

   localparam int EV_START = 32'h1000;
   localparam int EV_STOP  = 32'h2000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic [7:0] deviceaddw = 8'h00;
   logic [7:0] wraddr = 8'h00;
   logic [7:0] wrdat = 8'h00;
   logic       sel = 1'b0;

   logic scl_a, sda_reg_a, en_a, busy_a, over_a, nack_a;
   logic scl_b, sda_reg_b, en_b, busy_b, over_b, nack_b;
   logic slv_drive = 1'b0;

   wire w_scl     = sel ? scl_b : scl_a;
   wire w_sda_reg = sel ? sda_reg_b : sda_reg_a;
   wire w_en      = sel ? en_b : en_a;
   wire w_busy    = sel ? busy_b : busy_a;
   wire w_over    = sel ? over_b : over_a;
   wire w_nack    = sel ? nack_b : nack_a;
   wire w_sda     = !((w_en && !w_sda_reg) || slv_drive);
   wire w_sda_a   = sel ? 1'b1 : w_sda;
   wire w_sda_b   = sel ? w_sda : 1'b1;

   i2c_write #(.CLK_DIV(4), .ACK_RETRY(3)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a),
      .deviceaddw(deviceaddw), .wraddr(wraddr), .wrdat(wrdat), .sda(w_sda_a),
      .scl(scl_a), .sda_reg(sda_reg_a), .en(en_a),
      .busy(busy_a), .over(over_a), .nack(nack_a)
   );

   i2c_write #(.CLK_DIV(2), .ACK_RETRY(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b),
      .deviceaddw(deviceaddw), .wraddr(wraddr), .wrdat(wrdat), .sda(w_sda_b),
      .scl(scl_b), .sda_reg(sda_reg_b), .en(en_b),
      .busy(busy_b), .over(over_b), .nack(nack_b)
   );

   always #5 clk = ~clk;

   int clk_cnt = 0;
   always @(posedge clk) clk_cnt <= clk_cnt + 1;

   // bus decoder and slave: logs START/STOP/bytes, ACKs or NACKs per config
   int   ev_q[$];
   int   ev_t[$];
   int   m_cnt = 0;
   int   m_bidx = 0;
   int   m_starts = 0;
   logic [7:0] m_sh = 8'h00;
   logic m_ack = 1'b0;
   logic m_pscl = 1'b1;
   logic m_psda = 1'b1;
   int   cfg_nack_byte = -1;
   int   cfg_nack_times = 0;
   int   cfg_start_base = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_cnt     <= 0;
         slv_drive <= 1'b0;
         m_pscl    <= 1'b1;
         m_psda    <= 1'b1;
      end else begin
         m_pscl <= w_scl;
         m_psda <= w_sda;
         if (m_pscl && w_scl && m_psda && !w_sda) begin
            ev_q.push_back(EV_START);
            ev_t.push_back(clk_cnt);
            m_cnt     <= 0;
            m_bidx    <= 0;
            m_starts  <= m_starts + 1;
            slv_drive <= 1'b0;
         end else if (m_pscl && w_scl && !m_psda && w_sda) begin
            ev_q.push_back(EV_STOP);
            ev_t.push_back(clk_cnt);
         end else if (!m_pscl && w_scl) begin
            if (m_cnt < 8) m_sh <= {m_sh[6:0], w_sda};
            else m_ack <= w_sda;
            m_cnt <= m_cnt + 1;
         end else if (m_pscl && !w_scl) begin
            if (m_cnt == 8) begin
               slv_drive <= !((m_bidx == cfg_nack_byte) &&
                              ((m_starts - cfg_start_base - 1) < cfg_nack_times));
            end else if (m_cnt == 9) begin
               ev_q.push_back(int'({m_ack, m_sh}));
               ev_t.push_back(clk_cnt);
               slv_drive <= 1'b0;
               m_cnt     <= 0;
               m_bidx    <= m_bidx + 1;
            end
         end
      end
   end

   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // transaction-level expectation: bus events, completion cycle, final nack
   int exp_q[$];
   int exp_over_cyc;
   bit exp_nack;

   task automatic model(input logic [7:0] dev, input logic [7:0] rg, input logic [7:0] dat,
                        input int nb, input int nt, input int retry, input int cdiv);
      logic [7:0] b[3];
      int q;
      bit fail;
      b[0] = dev;
      b[1] = rg;
      b[2] = dat;
      exp_q.delete();
      exp_nack = 1'b0;
      q = 0;
      for (int a = 0; a <= retry; a++) begin
         fail = (nb >= 0) && (a < nt);
         exp_q.push_back(EV_START);
         q += 4;
         for (int i = 0; i < 3; i++) begin
            bit nk;
            nk = fail && (i == nb);
            exp_q.push_back(int'({nk, b[i]}));
            q += 36;
            if (nk) break;
         end
         exp_q.push_back(EV_STOP);
         q += 4;
         if (!fail) break;
         if (a == retry) begin
            exp_nack = 1'b1;
            break;
         end
         q += 4;
      end
      exp_over_cyc = q * cdiv + 1;
   endtask

   task automatic set_start(input logic v);
      if (sel) start_b = v;
      else start_a = v;
   endtask

   task automatic run_txn(input logic s, input logic [7:0] dev, input logic [7:0] rg,
                          input logic [7:0] dat, input int nb, input int nt,
                          input int mid_cyc, input int abort_cyc);
      int cdiv, retry, over_cyc, busy_cnt, over_cnt, base_ev, n_got;
      cdiv  = s ? 2 : 4;
      retry = s ? 0 : 3;
      @(negedge clk);
      sel            = s;
      cfg_nack_byte  = nb;
      cfg_nack_times = nt;
      cfg_start_base = m_starts;
      base_ev        = ev_q.size();
      model(dev, rg, dat, nb, nt, retry, cdiv);
      deviceaddw = dev;
      wraddr     = rg;
      wrdat      = dat;
      set_start(1'b1);
      @(posedge clk);
      #1;
      set_start(1'b0);
      over_cyc = 0;
      busy_cnt = 0;
      over_cnt = 0;
      for (int cyc = 1; cyc <= exp_over_cyc + 6; cyc++) begin
         if (cyc == 1) begin
            chk("busy_first", w_busy, 1'b1);
            chk("nack_cleared", w_nack, 1'b0);
         end
         if (cyc == mid_cyc) begin
            set_start(1'b1);
            wrdat = 8'hAA;
         end else if (cyc == mid_cyc + 1) begin
            set_start(1'b0);
         end
         if (cyc == abort_cyc) begin
            rst_n = 1'b0;
            #1;
            chk("rst_scl", w_scl, 1'b1);
            chk("rst_sda_reg", w_sda_reg, 1'b1);
            chk("rst_en", w_en, 1'b1);
            chk("rst_busy", w_busy, 1'b0);
            chk("rst_over", w_over, 1'b0);
            repeat (2) @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (w_busy) busy_cnt++;
         if (w_over) begin
            over_cnt++;
            if (over_cyc == 0) begin
               over_cyc = cyc;
               chk("nack_at_over", w_nack, exp_nack);
            end
         end
         @(posedge clk);
         #1;
      end
      chk("over_cycle", over_cyc, exp_over_cyc);
      chk("busy_cycles", busy_cnt, exp_over_cyc - 1);
      chk("over_pulses", over_cnt, 1);
      chk("nack_hold", w_nack, exp_nack);
      chk("idle_scl", w_scl, 1'b1);
      chk("idle_sda", w_sda, 1'b1);
      n_got = ev_q.size() - base_ev;
      chk("ev_count", n_got, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
         chk("bus_event", ev_q[base_ev + i], exp_q[i]);
      end
      // STOP Q3, four BUF quarters and START Q0 separate the STOP and START edges
      for (int i = base_ev + 1; i < ev_q.size(); i++) begin
         if (ev_q[i] == EV_START && ev_q[i-1] == EV_STOP) begin
            chk("buf_gap", ev_t[i] - ev_t[i-1], 6 * cdiv);
         end
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_scl", scl_a, 1'b1);
      chk("reset_sda_reg", sda_reg_a, 1'b1);
      chk("reset_en", en_a, 1'b1);
      chk("reset_busy", busy_a, 1'b0);
      chk("reset_over", over_a, 1'b0);
      chk("reset_nack", nack_a, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      run_txn(1'b0, 8'hD0, 8'h0E, 8'h1C, -1, 0, 0, 0);
      run_txn(1'b0, 8'hD0, 8'h0E, 8'h1C, 0, 1, 0, 0);
      run_txn(1'b0, 8'hD0, 8'h0E, 8'h1C, 2, 99, 0, 0);
      run_txn(1'b0, 8'hD0, 8'h0E, 8'h1C, -1, 0, 50, 0);
      run_txn(1'b1, 8'hD0, 8'h0E, 8'h1C, 1, 99, 0, 0);
      // bit 5 of wraddr occupies quarters 48..51
      run_txn(1'b0, 8'hD0, 8'h0E, 8'h1C, -1, 0, 0, 48 * 4 + 2);
      run_txn(1'b0, 8'hD0, 8'h0E, 8'h1C, -1, 0, 0, 0);

      for (int k = 0; k < 10; k++) begin
         int r;
         logic s;
         r = $urandom_range(0, 3);
         s = 1'($urandom_range(0, 1));
         run_txn(s, 8'($urandom), 8'($urandom), 8'($urandom),
                 (r == 3) ? -1 : r, $urandom_range(0, 5), 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
